branch_resolve_unit: RTL and testbench

Parametrised, pipelined successor to the single-cycle branch comparator. It evaluates all six conditional-branch conditions (BEQ/BNE/BLT/BGE/BLTU/BGEU) at configurable width and computes the branch target. It checks the outcome against the fetch-stage prediction and holds a redirect request until fetch acknowledges it. It sits in EX, between operand bypass and writeback/fetch redirect.

---
 rtl/branch_resolve_unit_pkg.sv | 28 ++
 rtl/branch_resolve_unit_cond_eval.sv | 42 ++++
 rtl/branch_resolve_unit.sv | 204 ++++++++++++++++++++
 tb/tb_branch_resolve_unit.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_resolve_unit_pkg.sv
// ============================================================================
// Module : branch_resolve_unit_pkg
// Brief  : Branch condition encodings, redirect FSM states, parameter checks.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package branch_resolve_unit_pkg;

    localparam logic [2:0] BR_EQ  = 3'b000;
    localparam logic [2:0] BR_NE  = 3'b001;
    localparam logic [2:0] BR_LT  = 3'b100;
    localparam logic [2:0] BR_GE  = 3'b101;
    localparam logic [2:0] BR_LTU = 3'b110;
    localparam logic [2:0] BR_GEU = 3'b111;

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        REDIRECT = 1'b1
    } brs_state_e;

    function automatic bit pipe_stages_legal(input int n);
        return (n == 1) || (n == 2);
    endfunction

endpackage

`default_nettype wire

// File: rtl/branch_resolve_unit_cond_eval.sv
// ============================================================================
// Module : br_cond_eval
// Brief  : Combinational operand compare and branch direction from funct3.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module br_cond_eval
    import branch_resolve_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] i_rs1,
    input  logic [XLEN-1:0] i_rs2,
    input  logic [2:0]      i_funct3,
    output logic            o_eq,
    output logic            o_slt,
    output logic            o_ult,
    output logic            o_taken
);

    assign o_eq  = (i_rs1 == i_rs2);
    assign o_slt = ($signed(i_rs1) < $signed(i_rs2));
    assign o_ult = (i_rs1 < i_rs2);

    // Encodings 010/011 are not branches and resolve not-taken.
    always_comb begin
        o_taken = 1'b0;
        case (i_funct3)
            BR_EQ:   o_taken = o_eq;
            BR_NE:   o_taken = !o_eq;
            BR_LT:   o_taken = o_slt;
            BR_GE:   o_taken = !o_slt;
            BR_LTU:  o_taken = o_ult;
            BR_GEU:  o_taken = !o_ult;
            default: o_taken = 1'b0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/branch_resolve_unit.sv
// ============================================================================
// Module : branch_resolve_unit
// Brief  : Pipelined branch resolution with mispredict redirect and counter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module branch_resolve_unit
    import branch_resolve_unit_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int PIPE_STAGES = 2,
    parameter int CNT_W       = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [2:0]       i_funct3,
    input  logic [XLEN-1:0]  i_rs1,
    input  logic [XLEN-1:0]  i_rs2,
    input  logic [XLEN-1:0]  i_pc,
    input  logic [XLEN-1:0]  i_imm,
    input  logic             i_pred_taken,
    input  logic [XLEN-1:0]  i_pred_target,
    input  logic             i_flush,
    output logic             o_valid,
    input  logic             i_ready,
    output logic             o_brEq,
    output logic             o_brLT,
    output logic             o_taken,
    output logic [XLEN-1:0]  o_target,
    output logic             o_mispredict,
    output logic             o_redirect_valid,
    output logic [XLEN-1:0]  o_redirect_pc,
    input  logic             i_redirect_ack,
    output logic [CNT_W-1:0] o_mispredict_count
);

    generate
        if (!pipe_stages_legal(PIPE_STAGES)) begin : g_bad_pipe_stages
            $error("branch_resolve_unit: PIPE_STAGES must be 1 or 2");
        end
    endgenerate

    logic            w_eq, w_slt, w_ult, w_taken;
    logic            w_accept, w_fire, w_s1_adv;
    logic            w_out_misp;
    logic [XLEN-1:0] w_out_rpc;
    logic            w_s1_lt, w_s1_misp;
    logic [XLEN-1:0] w_s1_rpc;

    logic            s1_valid_q, s1_eq_q, s1_slt_q, s1_ult_q, s1_taken_q;
    logic            s1_unsigned_q, s1_pred_taken_q;
    logic [XLEN-1:0] s1_target_q, s1_pc4_q, s1_pred_target_q;

    brs_state_e      state_q;
    logic            redir_valid_q;
    logic [XLEN-1:0] redir_pc_q;
    logic [CNT_W-1:0] cnt_q;

    br_cond_eval #(.XLEN(XLEN)) u_cond (
        .i_rs1    (i_rs1),
        .i_rs2    (i_rs2),
        .i_funct3 (i_funct3),
        .o_eq     (w_eq),
        .o_slt    (w_slt),
        .o_ult    (w_ult),
        .o_taken  (w_taken)
    );

    assign o_ready  = (state_q == IDLE) && !i_flush && (!s1_valid_q || w_s1_adv);
    assign w_accept = i_valid && o_ready;
    assign w_fire   = o_valid && i_ready;

    assign w_s1_lt   = s1_unsigned_q ? s1_ult_q : s1_slt_q;
    assign w_s1_misp = (s1_taken_q != s1_pred_taken_q) ||
                       (s1_taken_q && (s1_target_q != s1_pred_target_q));
    assign w_s1_rpc  = s1_taken_q ? s1_target_q : s1_pc4_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s1_valid_q       <= 1'b0;
            s1_eq_q          <= 1'b0;
            s1_slt_q         <= 1'b0;
            s1_ult_q         <= 1'b0;
            s1_taken_q       <= 1'b0;
            s1_unsigned_q    <= 1'b0;
            s1_pred_taken_q  <= 1'b0;
            s1_target_q      <= '0;
            s1_pc4_q         <= '0;
            s1_pred_target_q <= '0;
        end else if (i_flush) begin
            s1_valid_q <= 1'b0;
        end else if (!s1_valid_q || w_s1_adv) begin
            s1_valid_q <= w_accept;
            if (w_accept) begin
                s1_eq_q          <= w_eq;
                s1_slt_q         <= w_slt;
                s1_ult_q         <= w_ult;
                s1_taken_q       <= w_taken;
                s1_unsigned_q    <= i_funct3[1];
                s1_pred_taken_q  <= i_pred_taken;
                s1_target_q      <= i_pc + i_imm;
                s1_pc4_q         <= i_pc + XLEN'(4);
                s1_pred_target_q <= i_pred_target;
            end
        end
    end

    generate
        if (PIPE_STAGES == 2) begin : g_two_stage
            logic            s2_valid_q, s2_eq_q, s2_lt_q, s2_taken_q, s2_misp_q;
            logic [XLEN-1:0] s2_target_q, s2_rpc_q;

            assign w_s1_adv = !s2_valid_q || w_fire;

            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    s2_valid_q  <= 1'b0;
                    s2_eq_q     <= 1'b0;
                    s2_lt_q     <= 1'b0;
                    s2_taken_q  <= 1'b0;
                    s2_misp_q   <= 1'b0;
                    s2_target_q <= '0;
                    s2_rpc_q    <= '0;
                end else if (i_flush) begin
                    s2_valid_q <= 1'b0;
                end else if (w_s1_adv) begin
                    s2_valid_q <= s1_valid_q;
                    if (s1_valid_q) begin
                        s2_eq_q     <= s1_eq_q;
                        s2_lt_q     <= w_s1_lt;
                        s2_taken_q  <= s1_taken_q;
                        s2_misp_q   <= w_s1_misp;
                        s2_target_q <= s1_target_q;
                        s2_rpc_q    <= w_s1_rpc;
                    end
                end
            end

            assign o_valid      = s2_valid_q;
            assign o_brEq       = s2_eq_q;
            assign o_brLT       = s2_lt_q;
            assign o_taken      = s2_taken_q;
            assign o_target     = s2_target_q;
            assign o_mispredict = s2_misp_q;
            assign w_out_rpc    = s2_rpc_q;
        end else begin : g_one_stage
            assign w_s1_adv     = w_fire;
            assign o_valid      = s1_valid_q;
            assign o_brEq       = s1_eq_q;
            assign o_brLT       = w_s1_lt;
            assign o_taken      = s1_taken_q;
            assign o_target     = s1_target_q;
            assign o_mispredict = w_s1_misp;
            assign w_out_rpc    = w_s1_rpc;
        end
    endgenerate

    assign w_out_misp = o_mispredict;

    // Flush wins over a result handshaking in the same cycle: no count, no redirect.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q       <= IDLE;
            redir_valid_q <= 1'b0;
            redir_pc_q    <= '0;
            cnt_q         <= '0;
        end else if (i_flush) begin
            state_q       <= IDLE;
            redir_valid_q <= 1'b0;
        end else begin
            if (w_fire && w_out_misp && (cnt_q != {CNT_W{1'b1}}))
                cnt_q <= cnt_q + CNT_W'(1);
            case (state_q)
                IDLE: begin
                    if (w_fire && w_out_misp) begin
                        state_q       <= REDIRECT;
                        redir_valid_q <= 1'b1;
                        redir_pc_q    <= w_out_rpc;
                    end
                end
                REDIRECT: begin
                    if (i_redirect_ack) begin
                        state_q       <= IDLE;
                        redir_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q       <= IDLE;
                    redir_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign o_redirect_valid   = redir_valid_q;
    assign o_redirect_pc      = redir_pc_q;
    assign o_mispredict_count = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_branch_resolve_unit.sv
// ============================================================================
// Module : tb_branch_resolve_unit
// Brief  : Directed self-checking bench with a per-cycle reference model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_branch_resolve_unit;
    import branch_resolve_unit_pkg::*;

    localparam int PIPE = 2;
    localparam int CMAX = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // 32-bit, two-stage, 2-bit counter instance
    logic        rst, i_valid, o_ready, pt, flush, o_valid, i_ready;
    logic        brEq, brLT, taken, misp, rv, ack;
    logic [2:0]  f3;
    logic [31:0] rs1, rs2, pc, imm, ptgt, target, rpc;
    logic [1:0]  cnt;

    branch_resolve_unit #(.XLEN(32), .PIPE_STAGES(PIPE), .CNT_W(2)) dut (
        .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .o_ready(o_ready),
        .i_funct3(f3), .i_rs1(rs1), .i_rs2(rs2), .i_pc(pc), .i_imm(imm),
        .i_pred_taken(pt), .i_pred_target(ptgt), .i_flush(flush),
        .o_valid(o_valid), .i_ready(i_ready), .o_brEq(brEq), .o_brLT(brLT),
        .o_taken(taken), .o_target(target), .o_mispredict(misp),
        .o_redirect_valid(rv), .o_redirect_pc(rpc), .i_redirect_ack(ack),
        .o_mispredict_count(cnt)
    );

    // 64-bit, single-stage instance
    logic        b_rst, b_valid, b_ready, b_pt, b_flush, b_ovalid, b_iready;
    logic        b_eq, b_lt, b_taken, b_misp, b_rv, b_ack;
    logic [2:0]  b_f3;
    logic [63:0] b_rs1, b_rs2, b_pc, b_imm, b_ptgt, b_target, b_rpc;
    logic [15:0] b_cnt;

    branch_resolve_unit #(.XLEN(64), .PIPE_STAGES(1), .CNT_W(16)) dut64 (
        .i_clk(clk), .i_rst(b_rst), .i_valid(b_valid), .o_ready(b_ready),
        .i_funct3(b_f3), .i_rs1(b_rs1), .i_rs2(b_rs2), .i_pc(b_pc), .i_imm(b_imm),
        .i_pred_taken(b_pt), .i_pred_target(b_ptgt), .i_flush(b_flush),
        .o_valid(b_ovalid), .i_ready(b_iready), .o_brEq(b_eq), .o_brLT(b_lt),
        .o_taken(b_taken), .o_target(b_target), .o_mispredict(b_misp),
        .o_redirect_valid(b_rv), .o_redirect_pc(b_rpc), .i_redirect_ack(b_ack),
        .o_mispredict_count(b_cnt)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s timed out", name);
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic        eq;
        logic        lt;
        logic        taken;
        logic [31:0] target;
        logic [31:0] rpc;
        logic        misp;
        int          age;
    } exp_t;

    exp_t        mq[$];
    logic        m_redir = 1'b0;
    logic [31:0] m_rpc = '0;
    int          m_cnt = 0;
    int          dut_fires = 0;

    function automatic exp_t model_op(input logic [2:0] fn, input logic [31:0] a,
                                      input logic [31:0] b, input logic [31:0] p,
                                      input logic [31:0] im, input logic ptk,
                                      input logic [31:0] ptg);
        exp_t e;
        int   sa, sb;
        sa = a;
        sb = b;
        e.eq = (a == b);
        e.lt = fn[1] ? (a < b) : (sa < sb);
        case (fn)
            3'd0: e.taken = e.eq;
            3'd1: e.taken = !e.eq;
            3'd4, 3'd6: e.taken = e.lt;
            3'd5, 3'd7: e.taken = !e.lt;
            default: e.taken = 1'b0;
        endcase
        e.target = p + im;
        e.rpc    = e.taken ? e.target : p + 32'd4;
        e.misp   = (e.taken != ptk) || (e.taken && (e.target != ptg));
        e.age    = 1;
        return e;
    endfunction

    always @(negedge clk) begin
        logic ev, fire, rdy, fm;
        exp_t e;
        if (rst) begin
            mq.delete();
            m_redir = 1'b0;
            m_rpc   = '0;
            m_cnt   = 0;
        end else begin
            ev = (mq.size() > 0) && (mq[0].age >= PIPE);
            chk("o_valid", o_valid, ev);
            if (ev && o_valid) begin
                chk("o_brEq", brEq, mq[0].eq);
                chk("o_brLT", brLT, mq[0].lt);
                chk("o_taken", taken, mq[0].taken);
                chk("o_target", target, mq[0].target);
                chk("o_mispredict", misp, mq[0].misp);
            end
            chk("o_redirect_valid", rv, m_redir);
            if (m_redir) chk("o_redirect_pc", rpc, m_rpc);
            chk("o_mispredict_count", cnt, m_cnt);
            fire = ev && i_ready;
            rdy  = !m_redir && !flush && ((mq.size() < PIPE) || fire);
            chk("o_ready", o_ready, rdy);
            if (o_valid && i_ready && !flush) dut_fires++;
            if (flush) begin
                mq.delete();
                m_redir = 1'b0;
            end else begin
                fm = 1'b0;
                if (fire) begin
                    e  = mq.pop_front();
                    fm = e.misp;
                end
                if (fm && (m_cnt < CMAX)) m_cnt++;
                if (m_redir) begin
                    if (ack) m_redir = 1'b0;
                end else if (fm) begin
                    m_redir = 1'b1;
                    m_rpc   = e.rpc;
                end
            end
            for (int i = 0; i < mq.size(); i++) mq[i].age++;
            if (rdy && i_valid) mq.push_back(model_op(f3, rs1, rs2, pc, imm, pt, ptgt));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send_op(input logic [2:0] fn, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] p, input logic [31:0] im, input logic ptk,
                           input logic [31:0] ptg, output int waits);
        logic acc;
        acc = 1'b0;
        waits = 0;
        i_valid = 1'b1; f3 = fn; rs1 = a; rs2 = b; pc = p; imm = im; pt = ptk; ptgt = ptg;
        for (int k = 0; k < 50 && !acc; k++) begin
            @(negedge clk);
            acc = o_ready;
            @(posedge clk);
            #1;
            if (!acc) waits++;
        end
        i_valid = 1'b0;
        if (!acc) timeout_fail("send_op");
    endtask

    task automatic wait_out(output int n);
        logic seen;
        seen = 1'b0;
        n = 0;
        for (int k = 0; k < 30 && !seen; k++) begin
            @(negedge clk);
            n++;
            seen = o_valid;
        end
        if (!seen) timeout_fail("wait_out");
    endtask

    task automatic ack_redirect();
        logic seen;
        seen = 1'b0;
        for (int k = 0; k < 30 && !seen; k++) begin
            @(negedge clk);
            seen = rv;
        end
        if (!seen) timeout_fail("ack_redirect");
        @(posedge clk); #1 ack = 1'b1;
        @(posedge clk); #1 ack = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int w, n, w3, fires0;
        rst = 1'b1; i_valid = 1'b0; f3 = '0; rs1 = '0; rs2 = '0; pc = '0; imm = '0;
        pt = 1'b0; ptgt = '0; flush = 1'b0; i_ready = 1'b1; ack = 1'b0;
        b_rst = 1'b1; b_valid = 1'b0; b_f3 = '0; b_rs1 = '0; b_rs2 = '0; b_pc = '0;
        b_imm = '0; b_pt = 1'b0; b_ptgt = '0; b_flush = 1'b0; b_iready = 1'b1; b_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0; b_rst = 1'b0;

        @(negedge clk);
        chk("rst_valid", o_valid, 0);
        chk("rst_redirect_valid", rv, 0);
        chk("rst_redirect_pc", rpc, 0);
        chk("rst_count", cnt, 0);
        chk("rst_target", target, 0);
        chk("rst_taken", taken, 0);
        chk("rst_ready", o_ready, 1);
        @(posedge clk); #1;

        // BLT -1 < 1 signed, predicted not-taken
        send_op(BR_LT, 32'hFFFF_FFFF, 32'd1, 32'h1000, 32'h40, 1'b0, 32'h0, w);
        wait_out(n);
        chk("blt_latency", n, 2);
        chk("blt_taken", taken, 1);
        chk("blt_brLT", brLT, 1);
        chk("blt_misp", misp, 1);
        chk("blt_target", target, 32'h1040);
        @(negedge clk);
        chk("blt_redirect_valid", rv, 1);
        chk("blt_redirect_pc", rpc, 32'h1040);
        chk("blt_count", cnt, 1);
        ack_redirect();

        // BLTU same operands: 0xFFFFFFFF is not below 1 unsigned
        send_op(BR_LTU, 32'hFFFF_FFFF, 32'd1, 32'h2000, 32'h40, 1'b0, 32'h0, w);
        wait_out(n);
        chk("bltu_taken", taken, 0);
        chk("bltu_brLT", brLT, 0);
        chk("bltu_misp", misp, 0);
        @(negedge clk);
        chk("bltu_redirect_valid", rv, 0);
        chk("bltu_count", cnt, 1);
        @(posedge clk); #1;

        // Flush with redirect pending and both stages occupied
        send_op(BR_NE, 32'd3, 32'd3, 32'h200, 32'h10, 1'b1, 32'h210, w);
        send_op(BR_EQ, 32'd7, 32'd7, 32'h300, 32'h8, 1'b0, 32'h0, w);
        send_op(BR_GE, 32'd5, 32'd3, 32'h500, 32'h20, 1'b1, 32'h520, w);
        chk("flush_setup_waits", w, 0);
        flush = 1'b1;
        i_valid = 1'b1; f3 = BR_EQ; rs1 = 32'd1; rs2 = 32'd2; pc = 32'h600; imm = 32'h4;
        pt = 1'b1; ptgt = 32'h604;
        @(negedge clk);
        chk("flush_ready", o_ready, 0);
        chk("flush_pre_redirect_valid", rv, 1);
        chk("flush_pre_redirect_pc", rpc, 32'h204);
        chk("flush_pre_count", cnt, 2);
        @(posedge clk); #1 flush = 1'b0; i_valid = 1'b0;
        @(negedge clk);
        chk("flush_redirect_valid", rv, 0);
        chk("flush_valid", o_valid, 0);
        chk("flush_count", cnt, 2);
        repeat (3) @(posedge clk);
        #1;

        // BEQ taken, right direction but wrong target
        send_op(BR_EQ, 32'd5, 32'd5, 32'h100, 32'h20, 1'b1, 32'h124, w);
        wait_out(n);
        chk("beq_brEq", brEq, 1);
        chk("beq_taken", taken, 1);
        chk("beq_misp", misp, 1);
        chk("beq_target", target, 32'h120);
        @(negedge clk);
        chk("beq_redirect_pc", rpc, 32'h120);
        chk("beq_count", cnt, 3);
        ack_redirect();
        @(posedge clk); #1;

        // Four back-to-back ops while downstream stalls for three cycles
        fires0 = dut_fires;
        fork
            begin
                i_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1 i_ready = 1'b1;
            end
            begin
                send_op(BR_NE,  32'd1, 32'd2, 32'h400, 32'h10, 1'b1, 32'h410, w);
                send_op(BR_GE,  32'hFFFF_FFFF, 32'd1, 32'h404, 32'h10, 1'b0, 32'h0, w);
                send_op(BR_GEU, 32'hFFFF_FFFF, 32'd1, 32'h408, 32'hFFFF_FFF8, 1'b1, 32'h400, w3);
                send_op(3'b010, 32'd9, 32'd9, 32'h40C, 32'h10, 1'b0, 32'h0, w);
            end
        join
        chk("stall_op3_waits", w3, 1);
        repeat (6) @(negedge clk);
        chk("stall_handshakes", dut_fires - fires0, 4);
        chk("stall_count", cnt, 3);
        @(posedge clk); #1;

        // Two more mispredicts: counter must saturate
        for (int j = 0; j < 2; j++) begin
            send_op(BR_NE, 32'd4, 32'd4, 32'h800, 32'h10, 1'b1, 32'h810, w);
            wait_out(n);
            ack_redirect();
        end
        @(negedge clk);
        chk("sat_count", cnt, 3);
        @(posedge clk); #1;

        // Reset with an op in flight
        send_op(BR_NE, 32'd6, 32'd6, 32'h900, 32'h10, 1'b1, 32'h910, w);
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("midrst_valid", o_valid, 0);
        chk("midrst_redirect_valid", rv, 0);
        chk("midrst_count", cnt, 0);
        repeat (4) @(negedge clk);

        // 64-bit single-stage instance: target wrap and unsigned compare
        @(posedge clk); #1;
        b_valid = 1'b1; b_f3 = BR_EQ; b_rs1 = 64'd0; b_rs2 = 64'd0;
        b_pc = 64'hFFFF_FFFF_FFFF_FFF0; b_imm = 64'h20; b_pt = 1'b1; b_ptgt = 64'h10;
        @(negedge clk);
        chk("x64_ready", b_ready, 1);
        @(posedge clk); #1 b_valid = 1'b0;
        @(negedge clk);
        chk("x64_valid", b_ovalid, 1);
        chk("x64_taken", b_taken, 1);
        chk("x64_target_wrap", b_target, 64'h10);
        chk("x64_misp", b_misp, 0);
        @(posedge clk); #1;
        b_valid = 1'b1; b_f3 = BR_LTU; b_rs1 = 64'd1; b_rs2 = 64'hFFFF_FFFF_FFFF_FFFF;
        b_pc = 64'h40; b_imm = 64'hFFFF_FFFF_FFFF_FFF8; b_pt = 1'b0; b_ptgt = 64'h0;
        @(negedge clk);
        chk("x64_ready2", b_ready, 1);
        @(posedge clk); #1 b_valid = 1'b0;
        @(negedge clk);
        chk("x64_valid2", b_ovalid, 1);
        chk("x64_brLT", b_lt, 1);
        chk("x64_target2", b_target, 64'h38);
        chk("x64_misp2", b_misp, 1);
        @(negedge clk);
        chk("x64_redirect_valid", b_rv, 1);
        chk("x64_redirect_pc", b_rpc, 64'h38);
        chk("x64_count", b_cnt, 1);

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
